// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32x32 register file with per-register pending-write scoreboard; optional macro WB_BYPASS_EN
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rd_wb,
  input  logic [XLEN-1:0] data_wb,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            issue_fire
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  // Entry 0 of both arrays is only ever cleared, so x0 and pend[0] stay 0.
  logic [XLEN-1:0]   regs [32];
  logic [PEND_W-1:0] pend [32];

  logic        busy1;
  logic        busy2;
  logic        rd_full;
  logic [31:0] inc;
  logic [31:0] dec;

  // A source is busy while it has writes in flight; with bypass, the last
  // pending write retiring this cycle no longer blocks its consumer.
  function automatic logic src_busy(input logic [4:0] s);
    logic b;
    b = (s != 5'd0) && (pend[s] != '0);
`ifdef WB_BYPASS_EN
    if ((pend[s] == PEND_ONE) && (rd_wb == s)) b = 1'b0;
`endif
    return b;
  endfunction

  // Read port: x0 is hard zero; with bypass, a same-cycle writeback wins.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
    logic [XLEN-1:0] v;
    v = (a == 5'd0) ? '0 : regs[a];
`ifdef WB_BYPASS_EN
    if ((a != 5'd0) && (rd_wb == a)) v = data_wb;
`endif
    return v;
  endfunction

  // Read data, hazard detection and issue handshake.
  always_comb begin
    rs1_data   = read_port(issue_rs1);
    rs2_data   = read_port(issue_rs2);
    busy1      = src_busy(issue_rs1);
    busy2      = src_busy(issue_rs2);
    rd_full    = (issue_rd != 5'd0) && (pend[issue_rd] == PEND_MAX);
    stall      = !rst && issue_valid && (busy1 || busy2 || rd_full);
    issue_fire = !rst && issue_valid && !stall;
  end

  // Per-register scoreboard events: a fired issue claims rd, a writeback retires one claim.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < 32; r++) begin
      inc[r] = issue_fire && (issue_rd == 5'(r));
      dec[r] = (rd_wb == 5'(r)) && (pend[r] != '0);
    end
  end

  // Register file commit and pending counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (rd_wb == 5'(r)) regs[r] <= data_wb;
        if (inc[r] && !dec[r]) pend[r] <= pend[r] + PEND_ONE;
        else if (dec[r] && !inc[r]) pend[r] <= pend[r] - PEND_ONE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;

  localparam int MAXP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_wb;
  logic [31:0] data_wb;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic        issue_fire;

  regfile_scoreboard #(.XLEN(32), .PEND_W(2)) dut (
    .clk(clk), .rst(rst), .rd_wb(rd_wb), .data_wb(data_wb),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .issue_fire(issue_fire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        fire;
    logic [31:0] d1;
    logic [31:0] d2;
    bit          chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural register values and outstanding write counts.
  logic [31:0] m_regs [32];
  int          m_pend [32];

  function automatic bit bypass_on();
`ifdef WB_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bypass_on() && rd_wb == a) return data_wb;
    return m_regs[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] s);
    if (s == 0) return 1'b0;
    if (m_pend[s] == 0) return 1'b0;
    if (bypass_on() && m_pend[s] == 1 && rd_wb == s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    if (rst || !issue_valid) return 1'b0;
    return m_busy(issue_rs1) || m_busy(issue_rs2) ||
           (issue_rd != 0 && m_pend[issue_rd] == MAXP);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 0;
    end
  endtask

  task automatic m_commit(input bit fired);
    bit retire;
    if (rst) begin
      m_reset();
    end else begin
      retire = (rd_wb != 0) && (m_pend[rd_wb] > 0);
      if (rd_wb != 0) m_regs[rd_wb] = data_wb;
      if (fired && issue_rd != 0) m_pend[issue_rd] = m_pend[issue_rd] + 1;
      if (retire) m_pend[rd_wb] = m_pend[rd_wb] - 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus: drive, predict, enqueue, then advance the model on the edge.
  task automatic step(input bit r, input logic [4:0] wb, input logic [31:0] wd,
                      input bit v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d);
    exp_t e;
    rst = r; rd_wb = wb; data_wb = wd;
    issue_valid = v; issue_rs1 = s1; issue_rs2 = s2; issue_rd = d;
    e.stall    = m_stall();
    e.fire     = !r && v && !e.stall;
    e.d1       = m_read(s1);
    e.d2       = m_read(s2);
    e.chk_data = !r;
    exp_q.push_back(e);
    @(posedge clk);
    m_commit(e.fire);
    #1;
  endtask

  // Monitor: compares the DUT against the oldest prediction, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", 32'(stall), 32'(e.stall));
        check("issue_fire", 32'(issue_fire), 32'(e.fire));
        if (e.chk_data) begin
          check("rs1_data", rs1_data, e.d1);
          check("rs2_data", rs2_data, e.d2);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; rd_wb = 0; data_wb = 0;
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    @(posedge clk);
    m_reset();
    #1;
    step(1, 0, 0, 0, 0, 0, 0);

    // All 32 addresses read back zero after reset.
    for (int i = 0; i < 32; i++) step(0, 0, 0, 1, 5'(i), 5'(31 - i), 0);

    // Plain write then read; rd_wb=0 must not write x0.
    step(0, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0, 0);
    step(0, 0, 32'h12345678, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);

    // RAW on x7: stall holds until writeback.
    step(0, 0, 0, 1, 0, 0, 7);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 7, 0, 0);
    step(0, 7, 32'h55, 1, 7, 0, 0);
    step(0, 0, 0, 1, 7, 0, 0);

    // Destination saturation on x3.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 2, 3);
    step(0, 0, 0, 1, 1, 2, 3);
    step(0, 0, 0, 1, 1, 2, 3);
    step(0, 3, 32'h33, 1, 1, 2, 3);
    step(0, 0, 0, 1, 1, 2, 3);
    for (int i = 0; i < 3; i++) step(0, 3, 32'h30 + 32'(i), 0, 0, 0, 0);

    // Simultaneous claim and retire on x9 keeps the count at one.
    step(0, 0, 0, 1, 0, 0, 9);
    step(0, 9, 32'h99, 1, 0, 0, 9);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 9, 0);
    step(0, 9, 32'h999, 1, 0, 9, 0);
    step(0, 0, 0, 1, 0, 9, 0);

    // Reset mid-flight clears scoreboard and data.
    step(0, 0, 0, 1, 0, 0, 4);
    step(0, 4, 32'hAAAA, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 4);
    step(1, 0, 0, 1, 4, 0, 0);
    step(0, 0, 0, 1, 4, 0, 0);

    // Randomised traffic concentrated on a few registers to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(199) == 0),
           ($urandom_range(2) == 0) ? 5'(0) : 5'($urandom_range(7)),
           $urandom,
           $urandom_range(3) != 0,
           5'($urandom_range(7)), 5'($urandom_range(7)),
           ($urandom_range(3) == 0) ? 5'(0) : 5'($urandom_range(7)));
    end
    step(0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
